// File: rtl/axi_slave_resp.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// axi_slave_resp
//
// AXI4 slave responder. It terminates write bursts (AW/W -> B) and read
// bursts (AR -> R) from an upstream master. A small byte-strobed word memory
// backs the data, so data written can be read back. The write and read
// channels run two independent FSMs, and these may be active at the same time.
//
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   aw*_i / awready_o : write address channel
//   w*_i  / wready_o  : write data channel
//   b*_o  / bready_i  : write response channel
//   ar*_i / arready_o : read address channel
//   r*_o  / rready_i  : read data channel
//   dbg_wstate_o      : current write FSM state (W_IDLE/W_DATA/W_RESP)
//   dbg_rstate_o      : current read FSM state (R_IDLE/R_WAIT/R_DATA)
//
// Handshake rule: a transfer occurs on a rising edge where valid and ready
// are both 1. A source holds valid and its payload stable until the transfer
// occurs. Every ready output depends only on registered state, never on the
// matching valid input.
//
// Addressing: word index = addr[log2(BPW) +: log2(MEM_DEPTH)]. Each beat
// moves to the next word, wrapping modulo MEM_DEPTH. AxSIZE is ignored. A
// burst type other than INCR is still carried out as INCR, but its response
// is SLVERR.
// ---------------------------------------------------------------------------
module axi_slave_resp #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 16,
    parameter int RD_LAT     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // write address
    input  logic [ID_WIDTH-1:0]       awid_i,
    input  logic [ADDR_WIDTH-1:0]     awaddr_i,
    input  logic [7:0]                awlen_i,
    input  logic [2:0]                awsize_i,
    input  logic [1:0]                awburst_i,
    input  logic                      awvalid_i,
    output logic                      awready_o,
    // write data
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   wstrb_i,
    input  logic                      wlast_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    // write response
    output logic [ID_WIDTH-1:0]       bid_o,
    output logic [1:0]                bresp_o,
    output logic                      bvalid_o,
    input  logic                      bready_i,
    // read address
    input  logic [ID_WIDTH-1:0]       arid_i,
    input  logic [ADDR_WIDTH-1:0]     araddr_i,
    input  logic [7:0]                arlen_i,
    input  logic [2:0]                arsize_i,
    input  logic [1:0]                arburst_i,
    input  logic                      arvalid_i,
    output logic                      arready_o,
    // read data
    output logic [ID_WIDTH-1:0]       rid_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic [1:0]                rresp_o,
    output logic                      rlast_o,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    // debug
    output logic [1:0]                dbg_wstate_o,
    output logic [1:0]                dbg_rstate_o
);

    localparam int BPW  = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(BPW);
    localparam int IDXW = $clog2(MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    // The address sizes and the address bits outside the word index play no
    // part in addressing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awsize_i, arsize_i, awaddr_i, araddr_i};

    // live_q goes high on the first edge after reset is released. Every ready
    // output is gated by live_q, so the outputs stay 0 for the first cycle
    // after release.
    logic live_q;

    // ------------------------------------------------------------------
    // Backing store
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    w_state_e            w_state_q, w_state_d;
    logic [ID_WIDTH-1:0] wid_q, wid_d;
    logic [IDXW-1:0]     widx_q, widx_d;
    logic [7:0]          wlen_q, wlen_d;
    logic [7:0]          wcnt_q, wcnt_d;
    logic                wbad_q, wbad_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                w_fire;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    r_state_e            r_state_q, r_state_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d;
    logic [IDXW-1:0]     ridx_q, ridx_d;
    logic [7:0]          rlen_q, rlen_d;
    logic [7:0]          rcnt_q, rcnt_d;
    logic                rbad_q, rbad_d;
    logic [3:0]          lat_q, lat_d;

    // ------------------------------------------------------------------
    // Write FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = w_state_q;
        wid_d     = wid_q;
        widx_d    = widx_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        wbad_d    = wbad_q;
        bresp_d   = bresp_q;
        w_fire    = 1'b0;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        bid_o     = '0;
        bresp_o   = '0;

        unique case (w_state_q)
            W_IDLE: begin
                awready_o = live_q;
                if (awvalid_i && live_q) begin
                    wid_d     = awid_i;
                    widx_d    = awaddr_i[OFFW +: IDXW];
                    wlen_d    = awlen_i;
                    wbad_d    = (awburst_i != BURST_INCR);
                    wcnt_d    = 8'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready_o = 1'b1;
                if (wvalid_i) begin
                    w_fire = 1'b1;
                    widx_d = widx_q + 1'b1;
                    wcnt_d = wcnt_q + 8'd1;
                    if (wlast_i) begin
                        // The response is an error if the burst type was bad,
                        // or if the master ended the burst on a beat other
                        // than beat awlen.
                        bresp_d   = (wbad_q || (wcnt_q != wlen_q)) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bvalid_o = 1'b1;
                bid_o    = wid_q;
                bresp_o  = bresp_q;
                if (bready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rbad_d    = rbad_q;
        lat_d     = lat_q;
        arready_o = 1'b0;
        rvalid_o  = 1'b0;
        rid_o     = '0;
        rdata_o   = '0;
        rresp_o   = '0;
        rlast_o   = 1'b0;

        unique case (r_state_q)
            R_IDLE: begin
                arready_o = live_q;
                if (arvalid_i && live_q) begin
                    rid_d  = arid_i;
                    ridx_d = araddr_i[OFFW +: IDXW];
                    rlen_d = arlen_i;
                    rbad_d = (arburst_i != BURST_INCR);
                    rcnt_d = 8'd0;
                    lat_d  = 4'(RD_LAT);
                    r_state_d = (RD_LAT == 0) ? R_DATA : R_WAIT;
                end
            end
            R_WAIT: begin
                // The wait covers RD_LAT cycles. It leaves as the counter
                // steps from 1 to 0, so the first beat comes RD_LAT cycles
                // after the cycle that follows the AR handshake.
                lat_d = lat_q - 4'd1;
                if (lat_q <= 4'd1) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                // The memory read is combinational. A write to the same
                // word in this cycle lands at the edge, so this beat returns
                // the old data.
                rvalid_o = 1'b1;
                rid_o    = rid_q;
                rdata_o  = mem_q[ridx_q];
                rresp_o  = rbad_q ? RESP_SLVERR : RESP_OKAY;
                rlast_o  = (rcnt_q == rlen_q);
                if (rready_i) begin
                    ridx_d = ridx_q + 1'b1;
                    rcnt_d = rcnt_q + 8'd1;
                    if (rcnt_q == rlen_q) begin
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            wid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wbad_q    <= 1'b0;
            bresp_q   <= '0;
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rbad_q    <= 1'b0;
            lat_q     <= '0;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            wid_q     <= wid_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wbad_q    <= wbad_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rbad_q    <= rbad_d;
            lat_q     <= lat_d;
        end
    end

    // Memory write. Only the byte lanes enabled by wstrb change. Reset
    // clears the whole store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_fire) begin
            for (int b = 0; b < BPW; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[widx_q][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign dbg_wstate_o = w_state_q;
    assign dbg_rstate_o = r_state_q;

endmodule
